// File: rtl/inc_arbiter.sv
// Round-robin arbiter sharing one incrementer between the PC path (port 0)
// and the stack/address-pointer path (port 1).
module inc_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic             b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic             b1,
  output logic [WIDTH-1:0] add_a,
  output logic             add_b,
  input  logic [WIDTH-1:0] add_o,
  output logic [WIDTH-1:0] result,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  logic   owner;
  logic   last;
  logic   win;
  logic   any_req;

  assign any_req = req0 | req1;

  // On a tie the port that was not served last goes next
  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req0 & req1):  win = ~last;
      (req1 & ~req0): win = 1'b1;
      default:        win = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      add_a  <= '0;
      add_b  <= 1'b0;
      result <= '0;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            add_a <= win ? a1 : a0;
            add_b <= win ? b1 : b0;
            owner <= win;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= add_o;
          gnt0   <= ~owner;
          gnt1   <= owner;
          last   <= owner;
          state  <= DONE;
        end
        DONE: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inc_arbiter.sv
// Bench for inc_arbiter: directed cases plus randomized traffic
// checked against a transaction-level model every cycle.
module tb_inc_arbiter;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        req0 = 1'b0;
  logic [15:0] a0 = '0;
  logic        b0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] a1 = '0;
  logic        b1 = 1'b0;
  logic [15:0] add_a;
  logic        add_b;
  logic [15:0] add_o;
  logic [15:0] result;
  logic        gnt0;
  logic        gnt1;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  assign add_o = add_a + {15'd0, add_b};

  inc_arbiter #(.WIDTH(16)) dut (
    .CLK(CLK),
    .RST_n(RST_n),
    .req0(req0),
    .a0(a0),
    .b0(b0),
    .req1(req1),
    .a1(a1),
    .b1(b1),
    .add_a(add_a),
    .add_b(add_b),
    .add_o(add_o),
    .result(result),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction model: edge index, next edge able to accept, grant edge
  int          e = 0;
  int          free_e = 0;
  int          gnt_e = -10;
  logic        m_last = 1'b1;
  logic        m_owner = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_add_a = '0;
  logic        m_add_b = 1'b0;
  logic [15:0] m_result = '0;
  logic        m_g0 = 1'b0;
  logic        m_g1 = 1'b0;
  logic        m_busy = 1'b0;

  initial forever begin
    @(posedge CLK or negedge RST_n);
    if (!RST_n) begin
      free_e = e + 1;
      gnt_e = -10;
      m_last = 1'b1;
      m_add_a = '0;
      m_add_b = 1'b0;
      m_result = '0;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      m_busy = 1'b0;
    end else begin
      logic w;
      int s;
      e = e + 1;
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (e == gnt_e) begin
        m_result = m_pend;
        if (m_owner) m_g1 = 1'b1;
        else m_g0 = 1'b1;
        m_last = m_owner;
      end
      if (e >= free_e && (req0 || req1)) begin
        w = (req0 && req1) ? !m_last : req1;
        m_add_a = w ? a1 : a0;
        m_add_b = w ? b1 : b0;
        s = (int'(m_add_a) + int'(m_add_b)) % 65536;
        m_pend = s[15:0];
        m_owner = w;
        gnt_e = e + 1;
        free_e = e + 3;
      end
      m_busy = (e < free_e - 1);
    end
  end

  initial forever begin
    @(negedge CLK);
    chk("add_a", 32'(add_a), 32'(m_add_a));
    chk("add_b", 32'(add_b), 32'(m_add_b));
    chk("result", 32'(result), 32'(m_result));
    chk("gnt0", 32'(gnt0), 32'(m_g0));
    chk("gnt1", 32'(gnt1), 32'(m_g1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("mutex", 32'(gnt0 & gnt1), 32'd0);
  end

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 3))
      0: return 16'hFFFF;
      1: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  int          c_n;
  int          c_edge [4];
  logic        c_port [4];
  logic [15:0] c_res [4];
  logic [15:0] res_exp [4];

  initial begin
    res_exp[0] = 16'h0011;
    res_exp[1] = 16'h0021;
    res_exp[2] = 16'h0011;
    res_exp[3] = 16'h0021;

    repeat (3) @(negedge CLK);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    RST_n = 1'b1;

    // single request on port 0
    @(negedge CLK);
    req0 = 1'b1; a0 = 16'h1234; b0 = 1'b1;
    @(posedge CLK); #1;
    chk("single_busy_k", 32'(busy), 32'd1);
    chk("single_gnt0_k", 32'(gnt0), 32'd0);
    chk("single_add_a", 32'(add_a), 32'h1234);
    @(posedge CLK); #1;
    chk("single_gnt0", 32'(gnt0), 32'd1);
    chk("single_result", 32'(result), 32'h1235);
    chk("single_gnt1", 32'(gnt1), 32'd0);
    chk("single_busy_k1", 32'(busy), 32'd1);
    req0 = 1'b0;
    @(posedge CLK); #1;
    chk("single_gnt0_off", 32'(gnt0), 32'd0);
    chk("single_busy_off", 32'(busy), 32'd0);
    repeat (2) begin
      @(posedge CLK); #1;
      chk("single_no_regrant", 32'(gnt0 | busy), 32'd0);
    end

    // wrap then pass-through on port 1
    @(negedge CLK);
    req1 = 1'b1; a1 = 16'hFFFF; b1 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("wrap_gnt1", 32'(gnt1), 32'd1);
    chk("wrap_result", 32'(result), 32'h0000);
    chk("wrap_gnt0", 32'(gnt0), 32'd0);
    req1 = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    req1 = 1'b1; a1 = 16'h00A5; b1 = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("pass_gnt1", 32'(gnt1), 32'd1);
    chk("pass_result", 32'(result), 32'h00A5);
    req1 = 1'b0;
    repeat (2) @(posedge CLK);

    // operand change after acceptance
    @(negedge CLK);
    req0 = 1'b1; a0 = 16'h0100; b0 = 1'b1;
    @(posedge CLK); #1;
    a0 = 16'h0FFF;
    @(posedge CLK); #1;
    chk("opchg_gnt0", 32'(gnt0), 32'd1);
    chk("opchg_result", 32'(result), 32'h0101);
    req0 = 1'b0;
    repeat (2) @(posedge CLK);

    // request raised during DONE waits for IDLE
    @(negedge CLK);
    req0 = 1'b1; a0 = 16'h0007; b0 = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("done_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    @(negedge CLK);
    req1 = 1'b1; a1 = 16'h0020; b1 = 1'b0;
    @(posedge CLK); #1;
    chk("done_ignored", 32'(busy), 32'd0);
    @(posedge CLK); #1;
    chk("done_accept", 32'(busy), 32'd1);
    chk("done_add_a", 32'(add_a), 32'h0020);
    @(posedge CLK); #1;
    chk("done_gnt1", 32'(gnt1), 32'd1);
    chk("done_result", 32'(result), 32'h0020);
    req1 = 1'b0;
    repeat (2) @(posedge CLK);

    // reset in the middle of EXEC
    @(negedge CLK);
    req0 = 1'b1; a0 = 16'h0055; b0 = 1'b1;
    @(posedge CLK); #1;
    #1 RST_n = 1'b0;
    #1;
    chk("mid_rst_gnt0", 32'(gnt0), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_add_a", 32'(add_a), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    req0 = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    repeat (4) begin
      @(posedge CLK); #1;
      chk("post_rst_quiet", 32'(gnt0 | busy), 32'd0);
    end

    // contention from reset: port 0 wins first, then alternate
    @(negedge CLK);
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    req0 = 1'b1; a0 = 16'h0010; b0 = 1'b1;
    req1 = 1'b1; a1 = 16'h0020; b1 = 1'b1;
    c_n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if ((gnt0 || gnt1) && c_n < 4) begin
        c_edge[c_n] = i;
        c_port[c_n] = gnt1;
        c_res[c_n] = result;
        c_n++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("cont_count", 32'(c_n), 32'd4);
    for (int j = 0; j < c_n; j++) begin
      chk("cont_port", 32'(c_port[j]), 32'(j % 2));
      chk("cont_result", 32'(c_res[j]), 32'(res_exp[j]));
      chk("cont_edge", 32'(c_edge[j]), 32'(1 + 3 * j));
    end
    repeat (3) @(posedge CLK);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if ($urandom_range(0, 399) == 0) begin
        #2 RST_n = 1'b0;
        @(negedge CLK);
        RST_n = 1'b1;
      end
      if (req0 && gnt0) begin
        if ($urandom_range(0, 3) != 0) req0 = 1'b0;
      end else if (!req0) begin
        req0 = ($urandom_range(0, 2) == 0);
      end
      if (req1 && gnt1) begin
        if ($urandom_range(0, 3) != 0) req1 = 1'b0;
      end else if (!req1) begin
        req1 = ($urandom_range(0, 2) == 0);
      end
      a0 = rand_op();
      b0 = 1'($urandom_range(0, 1));
      a1 = rand_op();
      b1 = 1'($urandom_range(0, 1));
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (5) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inc_arbiter.md
# inc_arbiter

Shares the single 16-bit incrementer between two requesters: port 0 is the PC update path and port 1 is the stack/address-pointer path. The block arbitrates round-robin, drives the incrementer's operand inputs from registers, captures its combinational sum, and returns the result with a one-cycle grant pulse to the winner. It sits in the datapath beside the incrementer and is sequenced by the control unit through the request lines.

## Interface
- `WIDTH`, 16, operand and result width; must match the incrementer.

- `CLK`  in  1  rising-edge clock
- `RST_n`  in  1  asynchronous active-low reset
- `req0`  in  1  port 0 request; level, held until `gnt0` is seen
- `a0`  in  WIDTH  port 0 operand
- `b0`  in  1  port 0 increment bit (0 or 1 added)
- `req1`  in  1  port 1 request
- `a1`  in  WIDTH  port 1 operand
- `b1`  in  1  port 1 increment bit
- `add_a`  out  WIDTH  registered operand to incrementer `I15`
- `add_b`  out  1  registered increment bit to incrementer `I1`
- `add_o`  in  WIDTH  incrementer sum `O` (combinational)
- `result`  out  WIDTH  registered sum, valid while a grant is high and held afterwards
- `gnt0`  out  1  one-cycle completion pulse to port 0
- `gnt1`  out  1  one-cycle completion pulse to port 1
- `busy`  out  1  high when the state is not IDLE

## Operation
- FSM has three states: IDLE, EXEC and DONE.
- **IDLE:**
  - If `req0` or `req1` is high, select the winner, then load `add_a`/`add_b` from the winner's `a`/`b`, set `owner`, and go to EXEC.
  - Otherwise stay in IDLE.
- **Arbitration:**
  - A single request wins outright.
  - If both ports request, the port not equal to `last` wins.
  - `last` updates to `owner` on entry to DONE.
- **EXEC:**
  - Capture `result <= add_o`.
  - Assert the owner's grant: `gnt0` if `owner` is 0, `gnt1` if `owner` is 1.
  - Go to DONE.
- **DONE:**
  - Grant is high for this cycle only.
  - Requests are ignored.
  - Go to IDLE; grant clears.
- **Requester rule:**
  - Deassert `req` on the clock edge at which `gnt` is sampled high.
  - A `req` still high when the FSM is back in IDLE is treated as a new request.
- **Operand stability:** `a`/`b` need only be valid on the edge when IDLE samples the request; they are registered there.
- **Arithmetic:**
  - `result = (a + b) mod 2^WIDTH`; carry is discarded.
  - 0xFFFF + 1 wraps to 0x0000.
  - `b` = 0 passes `a` through unchanged.
- **Mutual exclusion:** `gnt0` and `gnt1` are never high together.
- **Reset (asynchronous, any state, including mid-operation):**
  - State goes to IDLE.
  - `add_a`, `add_b`, `result`, `gnt0`, `gnt1` and `busy` go to 0.
  - `last` goes to 1, so port 0 wins the first tie.
  - An in-flight operation is discarded and produces no grant after reset release.

## Timing
- **Latency:**
  - Request sampled at edge k.
  - Operands drive the incrementer after k.
  - `result` and grant register at edge k+1 and are high for the cycle k+1..k+2.
  - FSM is back in IDLE at k+2.
  - The earliest next acceptance is edge k+3.
- **Throughput:** one operation per 3 cycles, with back-to-back requests alternating ports under contention.
- **Critical path:** `add_a` register → incrementer → `result` register, a full cycle.
- **`busy`:** goes high at edge k and low at edge k+2.
- **`result`:** holds its value until the next EXEC.
- **Reset release:** synchronous use only; the first request is sampled on the first rising edge with `RST_n` high.

## Test plan
- **Reset values:** assert `RST_n`=0 mid-EXEC with `req0`=1 → all outputs 0 immediately, no `gnt0` after release, `busy`=0.
- **Single request:** `req0`=1, `a0`=0x1234, `b0`=1 → `gnt0` pulse for 1 cycle at k+1 with `result`=0x1235, `gnt1` stays 0, `busy` high for 2 cycles.
- **Wrap and pass-through:**
  - `req1`, `a1`=0xFFFF, `b1`=1 → `result`=0x0000 with `gnt1`.
  - Then `a1`=0x00A5, `b1`=0 → `result`=0x00A5.
- **Contention:** `req0` and `req1` both held continuously after reset, with `a0`=0x0010 and `a1`=0x0020, `b`=1 → grants in order `gnt0`(0x0011), `gnt1`(0x0021), `gnt0`, `gnt1`, spaced 3 cycles apart, never overlapping.
- **Operand change after accept:** change `a0` from 0x0100 to 0x0FFF one cycle after acceptance → `result`=0x0101.
- **Request drop and DONE blocking:**
  - Drop `req0` on the grant edge → no second `gnt0`.
  - Raise `req1` during DONE → accepted only in the following IDLE cycle.
